// File: rtl/ppl_pixel_writer.sv
// rtl/ppl_pixel_writer.sv - texel fetch, write buffering and frame-tagged double-buffer writes (option: PPL_WR_BOUNDS_EN)
module ppl_pixel_writer #(
   parameter int H_DISP     = 1280,
   parameter int V_DISP     = 720,
   parameter int TEX_W      = 16,
   parameter int TEX_LAT    = 2,
   parameter int FIFO_DEPTH = 16
) (
   input  logic             clk_ppl,
   input  logic             rst,
   input  logic             valid,
   input  logic             vs,
   input  logic [19:0]      pixel_addr,
   input  logic [12:0]      texture_addr,
   output logic             tex_rd_en,
   output logic [12:0]      tex_rd_addr,
   input  logic [TEX_W-1:0] tex_rd_data,
   output logic             fb_wr_en,
   output logic [20:0]      fb_wr_addr,
   output logic [TEX_W-1:0] fb_wr_data,
   input  logic             fb_wr_ready,
   output logic             disp_sel,
   output logic             frame_done,
   output logic             overflow,
`ifdef PPL_WR_BOUNDS_EN
   output logic             oob_err,
`endif
   output logic             frame_skip
);
   // entry = {tag, pixel_addr, colour}; the output register is the first slot, MD slots sit behind it
   localparam int EW = 21 + TEX_W;
   localparam int MD = FIFO_DEPTH - 1;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + TEX_LAT + 2);
`ifdef PPL_WR_BOUNDS_EN
   localparam int unsigned PIX_LIMIT = H_DISP * V_DISP;
`endif

   // reject parameter sets the buffering and addressing cannot support
   if (TEX_LAT < 1 || TEX_LAT > 4 || FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
       H_DISP * V_DISP > 1048576) begin : g_bad_params
      $error("ppl_pixel_writer: illegal parameter set");
   end

   logic                vs_q, frame_tag, swap_pending;
   logic [TEX_LAT:0]    dl_vld, dl_tag;
   logic [19:0]         dl_addr [0:TEX_LAT];
   logic [EW-1:0]       mem [0:MD-1];
   logic [PW-1:0]       rd_ptr, wr_ptr, mem_cnt;
   logic [1:0][CW-1:0]  tag_cnt, cnt_nxt;
   logic                in_ok, take_edge, tag_now, full, fire, push, slot_free;
   logic                mem_pop, mem_push, old_tag, old_drained;
   logic [EW-1:0]       cap_entry;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(MD - 1)) ? '0 : p + PW'(1);
   endfunction

   // entry qualification, buffer handshake decisions and per-tag in-flight accounting
   always_comb begin
`ifdef PPL_WR_BOUNDS_EN
      in_ok = valid && (32'(pixel_addr) < PIX_LIMIT);
`else
      in_ok = valid;
`endif
      take_edge = vs && !vs_q && !swap_pending;
      tag_now   = frame_tag ^ take_edge;
      full      = fb_wr_en && (mem_cnt == PW'(MD));
      fire      = fb_wr_en && fb_wr_ready;
      push      = dl_vld[TEX_LAT] && !full;
      slot_free = !fb_wr_en || fire;
      mem_pop   = slot_free && (mem_cnt != '0);
      mem_push  = push && !(slot_free && (mem_cnt == '0));
      cap_entry = {dl_tag[TEX_LAT], dl_addr[TEX_LAT], tex_rd_data};
      cnt_nxt   = tag_cnt;
      for (int t = 0; t < 2; t++) begin
         cnt_nxt[t] = tag_cnt[t]
                    + CW'(in_ok && (tag_now == 1'(t)))
                    - CW'(dl_vld[TEX_LAT] && full && (dl_tag[TEX_LAT] == 1'(t)))
                    - CW'(fire && (fb_wr_addr[20] == 1'(t)));
      end
      old_tag     = !tag_now;
      old_drained = (cnt_nxt[old_tag] == '0);
   end

   // buffer storage behind the output register; pointers alone define its contents
   always_ff @(posedge clk_ppl) begin
      if (mem_push) mem[wr_ptr] <= cap_entry;
   end

   // read strobe, delay line, output register, pointers, frame tagging and sticky flags
   always_ff @(posedge clk_ppl) begin
      if (rst) begin
         vs_q         <= 1'b0;
         frame_tag    <= 1'b0;
         swap_pending <= 1'b0;
         tex_rd_en    <= 1'b0;
         tex_rd_addr  <= '0;
         dl_vld       <= '0;
         dl_tag       <= '0;
         for (int i = 0; i <= TEX_LAT; i++) dl_addr[i] <= '0;
         fb_wr_en     <= 1'b0;
         fb_wr_addr   <= '0;
         fb_wr_data   <= '0;
         rd_ptr       <= '0;
         wr_ptr       <= '0;
         mem_cnt      <= '0;
         tag_cnt      <= '0;
         disp_sel     <= 1'b0;
         frame_done   <= 1'b0;
         overflow     <= 1'b0;
         frame_skip   <= 1'b0;
`ifdef PPL_WR_BOUNDS_EN
         oob_err      <= 1'b0;
`endif
      end else begin
         vs_q      <= vs;
         tex_rd_en <= in_ok;
         if (in_ok) tex_rd_addr <= texture_addr;
`ifdef PPL_WR_BOUNDS_EN
         if (valid && !in_ok) oob_err <= 1'b1;
`endif
         dl_vld     <= {dl_vld[TEX_LAT-1:0], in_ok};
         dl_tag     <= {dl_tag[TEX_LAT-1:0], tag_now};
         dl_addr[0] <= pixel_addr;
         for (int i = 1; i <= TEX_LAT; i++) dl_addr[i] <= dl_addr[i-1];

         // a full buffer drops the arriving pixel even if the head leaves this cycle
         if (dl_vld[TEX_LAT] && full) overflow <= 1'b1;

         if (slot_free) begin
            fb_wr_en <= mem_pop || push;
            if (mem_pop) {fb_wr_addr, fb_wr_data} <= mem[rd_ptr];
            else if (push) {fb_wr_addr, fb_wr_data} <= cap_entry;
         end
         if (mem_pop)  rd_ptr <= ptr_inc(rd_ptr);
         if (mem_push) wr_ptr <= ptr_inc(wr_ptr);
         mem_cnt <= mem_cnt + PW'(mem_push) - PW'(mem_pop);
         tag_cnt <= cnt_nxt;

         // the tag flips on the accepted edge; the display flips once the old tag has drained
         frame_done <= 1'b0;
         if (vs && !vs_q && swap_pending) frame_skip <= 1'b1;
         if (take_edge) frame_tag <= !frame_tag;
         if ((swap_pending || take_edge) && old_drained) begin
            swap_pending <= 1'b0;
            disp_sel     <= old_tag;
            frame_done   <= 1'b1;
         end else if (take_edge) begin
            swap_pending <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_ppl_pixel_writer.sv
// tb/tb_ppl_pixel_writer.sv - directed and randomized bench for ppl_pixel_writer against a queue-level model
`timescale 1ns/1ps
module tb_ppl_pixel_writer;
   localparam int TEX_LAT = 2;
   localparam int DEPTH   = 16;
   localparam int LIMIT   = 1280 * 720;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid = 1'b0;
   logic        vs = 1'b0;
   logic [19:0] pixel_addr = '0;
   logic [12:0] texture_addr = '0;
   logic        tex_rd_en;
   logic [12:0] tex_rd_addr;
   logic [15:0] tex_rd_data;
   logic        fb_wr_en;
   logic [20:0] fb_wr_addr;
   logic [15:0] fb_wr_data;
   logic        fb_wr_ready = 1'b1;
   logic        disp_sel, frame_done, overflow, frame_skip;
`ifdef PPL_WR_BOUNDS_EN
   logic        oob_err;
`endif

   always #5 clk = ~clk;

   ppl_pixel_writer dut (
      .clk_ppl(clk), .rst(rst), .valid(valid), .vs(vs),
      .pixel_addr(pixel_addr), .texture_addr(texture_addr),
      .tex_rd_en(tex_rd_en), .tex_rd_addr(tex_rd_addr), .tex_rd_data(tex_rd_data),
      .fb_wr_en(fb_wr_en), .fb_wr_addr(fb_wr_addr), .fb_wr_data(fb_wr_data),
      .fb_wr_ready(fb_wr_ready), .disp_sel(disp_sel), .frame_done(frame_done),
      .overflow(overflow),
`ifdef PPL_WR_BOUNDS_EN
      .oob_err(oob_err),
`endif
      .frame_skip(frame_skip)
   );

   function automatic logic [15:0] rom_f(input logic [12:0] a);
      if (a == 13'h0042) return 16'hF800;
      return ({3'b000, a} * 16'h9E37) ^ 16'h3C5A;
   endfunction

   // texture ROM with TEX_LAT cycles of read latency
   logic [12:0] rom_a [1:TEX_LAT];
   always @(posedge clk) begin
      rom_a[1] <= tex_rd_addr;
      for (int i = 2; i <= TEX_LAT; i++) rom_a[i] <= rom_a[i-1];
   end
   assign tex_rd_data = rom_f(rom_a[TEX_LAT]);

   typedef struct { int arr; logic tag; logic [19:0] addr; logic [15:0] data; } pix_t;
   typedef struct { int c; logic [20:0] a; logic [15:0] d; } wr_t;

   pix_t pq[$];
   pix_t fq[$];
   wr_t  wlog[$];
   int   tlog[$];
   int   dlog[$];
   int   cyc = 0;
   int   cmp_n = 0;
   int   err_n = 0;
   bit   seen_rst = 1'b0;
   logic m_tex_en = 0, m_vs_q = 0, m_tag = 0, m_pend = 0, m_disp = 0;
   logic m_done = 0, m_ovf = 0, m_skip = 0, m_oob = 0;
   logic [12:0] m_tex_addr = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      cmp_n++;
      if (act !== exp) begin
         err_n++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic clear_logs();
      wlog.delete();
      tlog.delete();
      dlog.delete();
   endtask

   // queue-level reference: pixels wait in pq until their capture cycle, fq is the write buffer
   task automatic model_advance();
      pix_t a;
      bit   arr, full, fire, edge_v, acc, any_old;
      if (rst) begin
         pq.delete(); fq.delete();
         m_tex_en = 0; m_tex_addr = '0; m_vs_q = 0; m_tag = 0; m_pend = 0;
         m_disp = 0; m_done = 0; m_ovf = 0; m_skip = 0; m_oob = 0;
         return;
      end
      edge_v = vs && !m_vs_q;
      m_vs_q = vs;
      if (edge_v && m_pend) m_skip = 1;
      else if (edge_v) begin
         m_tag  = !m_tag;
         m_pend = 1;
      end
      acc = valid;
`ifdef PPL_WR_BOUNDS_EN
      if (valid && pixel_addr >= LIMIT) begin
         acc   = 0;
         m_oob = 1;
      end
`endif
      m_tex_en = acc;
      if (acc) begin
         m_tex_addr = texture_addr;
         pq.push_back('{cyc + 1 + TEX_LAT, m_tag, pixel_addr, rom_f(texture_addr)});
      end
      fire = (fq.size() != 0) && fb_wr_ready;
      full = (fq.size() == DEPTH);
      arr  = (pq.size() != 0) && (pq[0].arr == cyc);
      if (arr) a = pq.pop_front();
      if (fire) fq.delete(0);
      if (arr && full) m_ovf = 1;
      else if (arr) fq.push_back(a);
      m_done = 0;
      if (m_pend) begin
         any_old = 0;
         foreach (pq[i]) if (pq[i].tag != m_tag) any_old = 1;
         foreach (fq[i]) if (fq[i].tag != m_tag) any_old = 1;
         if (!any_old) begin
            m_pend = 0;
            m_disp = !m_tag;
            m_done = 1;
         end
      end
   endtask

   // compare every cycle mid-period, log events, then step the model with this cycle's inputs
   always @(negedge clk) begin
      if (seen_rst) begin
         chk("tex_rd_en", tex_rd_en, m_tex_en);
         if (m_tex_en) chk("tex_rd_addr", tex_rd_addr, m_tex_addr);
         chk("fb_wr_en", fb_wr_en, fq.size() != 0);
         if (fq.size() != 0) begin
            chk("fb_wr_addr", fb_wr_addr, {fq[0].tag, fq[0].addr});
            chk("fb_wr_data", fb_wr_data, fq[0].data);
         end
         chk("disp_sel", disp_sel, m_disp);
         chk("frame_done", frame_done, m_done);
         chk("overflow", overflow, m_ovf);
         chk("frame_skip", frame_skip, m_skip);
`ifdef PPL_WR_BOUNDS_EN
         chk("oob_err", oob_err, m_oob);
`endif
      end
      if (tex_rd_en === 1'b1) tlog.push_back(cyc);
      if (fb_wr_en === 1'b1 && fb_wr_ready) wlog.push_back('{cyc, fb_wr_addr, fb_wr_data});
      if (frame_done === 1'b1) dlog.push_back(cyc);
      model_advance();
      if (rst) seen_rst = 1'b1;
      cyc++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [19:0] pa, input logic [12:0] ta);
      valid = 1'b1;
      pixel_addr = pa;
      texture_addr = ta;
      tick();
      valid = 1'b0;
   endtask

   initial begin
      int v, e;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk("rst_tex_en", tex_rd_en, 0);
      chk("rst_tex_addr", tex_rd_addr, 0);
      chk("rst_fb_en", fb_wr_en, 0);
      chk("rst_fb_addr", fb_wr_addr, 0);
      chk("rst_fb_data", fb_wr_data, 0);
      chk("rst_flags", {disp_sel, frame_done, overflow, frame_skip}, 0);

      // single pixel, ready high
      repeat (5) tick();
      clear_logs();
      v = cyc;
      send(20'h00123, 13'h0042);
      repeat (8) tick();
      chk("sp_tex_cnt", tlog.size(), 1);
      if (tlog.size() >= 1) chk("sp_tex_lat", tlog[0] - v, 1);
      chk("sp_wr_cnt", wlog.size(), 1);
      if (wlog.size() >= 1) begin
         chk("sp_wr_lat", wlog[0].c - v, 4);
         chk("sp_wr_addr", wlog[0].a, 21'h000123);
         chk("sp_wr_data", wlog[0].d, 16'hF800);
      end

      // backpressure: 20 pixels into a 16-entry buffer
      clear_logs();
      fb_wr_ready = 1'b0;
      for (int i = 0; i < 20; i++) send(20'h00200 + 20'(i), 13'($urandom));
      repeat (6) tick();
      chk("bp_overflow", overflow, 1);
      chk("bp_head", fb_wr_addr, 21'h000200);
      fb_wr_ready = 1'b1;
      repeat (25) tick();
      chk("bp_wr_cnt", wlog.size(), 16);
      foreach (wlog[i]) chk("bp_order", wlog[i].a, 21'h000200 + 21'(i));

      // vs edge with 5 pixels in flight, 3 more after it
      clear_logs();
      for (int i = 0; i < 5; i++) send(20'h00300 + 20'(i), 13'($urandom));
      vs = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) send(20'h00310 + 20'(i), 13'($urandom));
      vs = 1'b0;
      repeat (12) tick();
      chk("vf_wr_cnt", wlog.size(), 8);
      chk("vf_done_cnt", dlog.size(), 1);
      if (wlog.size() == 8 && dlog.size() == 1) begin
         chk("vf_done_cyc", dlog[0] - wlog[4].c, 1);
         foreach (wlog[i]) chk("vf_tag", wlog[i].a[20], (i >= 5));
      end
      chk("vf_disp", disp_sel, 0);

      // vs edge on an empty pipeline
      clear_logs();
      e = cyc;
      vs = 1'b1;
      tick();
      vs = 1'b0;
      repeat (3) tick();
      chk("ve_done_cnt", dlog.size(), 1);
      if (dlog.size() >= 1) chk("ve_done_lat", dlog[0] - e, 1);
      chk("ve_disp", disp_sel, 1);

      // second edge while the swap is held by ready low
      clear_logs();
      fb_wr_ready = 1'b0;
      send(20'h00400, 13'h0011);
      repeat (6) tick();
      vs = 1'b1; tick(); vs = 1'b0; repeat (2) tick();
      vs = 1'b1; tick(); vs = 1'b0; repeat (2) tick();
      chk("sk_flag", frame_skip, 1);
      chk("sk_no_done", dlog.size(), 0);
      send(20'h00401, 13'h0012);
      repeat (6) tick();
      fb_wr_ready = 1'b1;
      repeat (6) tick();
      chk("sk_wr_cnt", wlog.size(), 2);
      if (wlog.size() == 2) begin
         chk("sk_old_px", wlog[0].a, 21'h000400);
         chk("sk_new_px", wlog[1].a, 21'h100401);
         chk("sk_done_cnt", dlog.size(), 1);
         if (dlog.size() == 1) chk("sk_done_cyc", dlog[0] - wlog[0].c, 1);
      end
      chk("sk_disp", disp_sel, 0);

      // reset with 8 pixels buffered
      fb_wr_ready = 1'b0;
      for (int i = 0; i < 8; i++) send(20'h00500 + 20'(i), 13'($urandom));
      repeat (6) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mr_outs", {tex_rd_en, fb_wr_en, disp_sel, frame_done, overflow, frame_skip}, 0);
      chk("mr_fb_addr", fb_wr_addr, 0);
      chk("mr_fb_data", fb_wr_data, 0);
      clear_logs();
      fb_wr_ready = 1'b1;
      v = cyc;
      send(20'h00600, 13'h0042);
      repeat (10) tick();
      chk("mr_wr_cnt", wlog.size(), 1);
      if (wlog.size() == 1) begin
         chk("mr_wr_lat", wlog[0].c - v, 4);
         chk("mr_wr_addr", wlog[0].a, 21'h000600);
      end

`ifdef PPL_WR_BOUNDS_EN
      clear_logs();
      send(20'd921600, 13'h0001);
      repeat (8) tick();
      chk("ob_tex_cnt", tlog.size(), 0);
      chk("ob_wr_cnt", wlog.size(), 0);
      chk("ob_flag", oob_err, 1);
      send(20'd921599, 13'h0002);
      repeat (8) tick();
      chk("ob_edge_wr", wlog.size(), 1);
`endif

      // randomized traffic with shifting backpressure, vs pulses and one mid-run reset
      for (int k = 0; k < 3000; k++) begin
         valid = ($urandom_range(0, 9) < 6);
         pixel_addr = 20'($urandom_range(0, LIMIT - 1));
         texture_addr = 13'($urandom);
         if (k < 1000)      fb_wr_ready = ($urandom_range(0, 9) < 9);
         else if (k < 2000) fb_wr_ready = ($urandom_range(0, 9) < 4);
         else               fb_wr_ready = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 39) == 0) vs = !vs;
         rst = (k == 1500);
         tick();
      end
      rst = 1'b0;
      valid = 1'b0;
      vs = 1'b0;
      fb_wr_ready = 1'b1;
      repeat (40) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
      $finish;
   end
endmodule
